// File: rtl/message_packer.sv
// message_packer: packs a serial decoded-message bit stream LSB-first into words,
// buffers them in a small show-ahead FIFO and presents them on a valid/ready port.
module message_packer #(
    parameter int unsigned N          = 1024,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int unsigned WORDS = N / WORD_W;
    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned CNT_W = $clog2(WORDS) + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic                    overflow_q, overflow_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [WORD_W-1:0]       mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]       mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   last_q, last_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;

    logic accept_c;
    logic word_done_c;
    logic frame_done_c;
    logic pop_c;
    logic full_c;
    logic wr_en_c;

    assign accept_c     = (state_q == S_PACK) && bit_valid;
    assign word_done_c  = accept_c && (bit_idx_q == IDX_W'(WORD_W - 1));
    assign frame_done_c = word_done_c && (word_cnt_q == CNT_W'(WORDS - 1));
    assign pop_c        = (occ_q != '0) && word_ready;
    assign full_c       = (occ_q == OCC_W'(FIFO_DEPTH));
    // A completed word is dropped only when the FIFO is full and nothing leaves this cycle.
    assign wr_en_c      = word_done_c && (!full_c || pop_c);

    assign word_out   = mem_q[rd_ptr_q];
    assign word_valid = (occ_q != '0);
    assign word_last  = last_q[rd_ptr_q];
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_idx_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PACK;
            S_PACK:  if (frame_done_c) state_d = S_DRAIN;
            S_DRAIN: if (occ_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Packing shift register, counters and FIFO bookkeeping.
    always_comb begin
        bit_idx_d  = bit_idx_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;

        if ((state_q == S_IDLE) && start) begin
            bit_idx_d  = '0;
            word_cnt_d = '0;
            shift_d    = '0;
            overflow_d = 1'b0;
        end

        if (accept_c) begin
            shift_d[bit_idx_q] = bit_in;
            bit_idx_d          = word_done_c ? '0 : bit_idx_q + IDX_W'(1);
            if (word_done_c) begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
        end

        if (word_done_c && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end

        if (wr_en_c) begin
            mem_d[wr_ptr_q]  = shift_d;
            last_d[wr_ptr_q] = (word_cnt_q == CNT_W'(WORDS - 1));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({wr_en_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Registered status outputs; done lands together with the return to IDLE.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DRAIN) && (occ_q == '0);
    end
endmodule
